if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the PC value loaded on reset.
REQ-002 SHALL have port Clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port PC  output  32  fetch address driven to the instruction memory.
REQ-005 SHALL have port IF_Instruction  input  32  word returned combinationally by the instruction memory for PC.
REQ-006 SHALL have port Stall  input  1  hold request from the hazard unit.
REQ-007 SHALL have port Flush  input  1  squash the IF/ID register contents.
REQ-008 SHALL have port Redirect  input  1  branch/jump taken.
REQ-009 SHALL have port RedirectTarget  input  32  target address for Redirect.
REQ-010 SHALL have port Halt  input  1  stop fetching.
REQ-011 SHALL have port ID_Instruction  output  32  registered instruction for decode.
REQ-012 SHALL have port ID_PCPlus4  output  32  registered PC+4 of ID_Instruction.
REQ-013 SHALL have port ID_Valid  output  1  ID_Instruction is real (0 = bubble).
REQ-014 SHALL have port Halted  output  1  high while in HALT state.

Function
REQ-015 SHALL implement two states: RUN and HALT; Halted = (state == HALT).
REQ-016 SHALL hold an internal pending-redirect flag PendV and a 32-bit PendT.
REQ-017 SHALL define a bubble as ID_Instruction=0, ID_PCPlus4=0, ID_Valid=0.
REQ-018 SHALL force the low two bits of any loaded target to 0 (word alignment).
REQ-019 SHALL compute PC+4 modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-020 SHALL, in RUN with Flush=1: load a bubble into IF/ID, clear PendV; PC <= RedirectTarget if Redirect=1, else PC holds; Stall and Halt are ignored this cycle.
REQ-021 SHALL, in RUN with Flush=0 and Halt=1: go to HALT, load a bubble, clear PendV, hold PC; Stall/Redirect are ignored.
REQ-022 SHALL, in RUN with Flush=0, Halt=0, Stall=1: hold PC and IF/ID; if Redirect=1 set PendV=1, PendT=RedirectTarget (newer overwrites older).
REQ-023 SHALL, in RUN with Flush=0, Halt=0, Stall=0: load IF/ID with IF_Instruction, PC+4, Valid=1 (delay-slot instruction kept); next PC = RedirectTarget if Redirect=1, else PendT if PendV=1, else PC+4; clear PendV.
REQ-024 SHALL, in HALT, hold PC, drive a bubble, ignore Stall/Flush/Redirect/Halt; exit only via reset.
REQ-025 SHALL have fetch-to-decode latency of exactly one clock: the word presented at cycle n appears on ID_Instruction after edge n+1.

Reset
REQ-026 SHALL, on Rst=0, immediately (without waiting for Clk) set PC=RESET_PC, IF/ID=bubble, PendV=0, PendT=0, state=RUN, Halted=0.
REQ-027 SHALL, on reset asserted mid-operation (pending redirect, HALT or stall), discard all of it and restart from RESET_PC on the first edge after Rst returns to 1.

Verification
REQ-028 Sequential fetch: Rst released, memory word k = 32'h1000_0000+k, no controls -> PC 0,4,8; after edge 2 ID_Instruction=32'h10000001, ID_PCPlus4=8, ID_Valid=1.
REQ-029 Stall+redirect: at PC=8 assert Stall and Redirect (target 32'h40) for 2 cycles, then drop both -> PC stays 8 during stall, ID holds; next edge ID gets word at 8, PC=32'h40.
REQ-030 Flush with redirect while stalled: PC=12, Stall=1, Flush=1, Redirect=1, target 32'h22 -> PC=32'h20, ID_Valid=0, PendV cleared.
REQ-031 Halt: at PC=16 assert Halt one cycle -> Halted=1, PC stays 16, ID_Valid=0 thereafter despite Redirect/Flush pulses.
REQ-032 Wrap: RESET_PC=32'hFFFFFFFC -> PC after first edge = 32'h00000000, ID_PCPlus4=0.
REQ-033 Async reset: assert Rst=0 mid-cycle while PendV=1 -> PC=RESET_PC and ID_Valid=0 before the next Clk edge; after release, the pending target is never taken.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Signal bundle between the instruction-fetch stage, instruction memory, hazard unit and decode.
// master: the fetch stage itself; slave: the surrounding pipeline/memory.
interface if_fetch_stage_if;
  logic [31:0] PC;
  logic [31:0] IF_Instruction;
  logic        Stall;
  logic        Flush;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        Halt;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PCPlus4;
  logic        ID_Valid;
  logic        Halted;

  modport master (
    output PC, ID_Instruction, ID_PCPlus4, ID_Valid, Halted,
    input  IF_Instruction, Stall, Flush, Redirect, RedirectTarget, Halt
  );

  modport slave (
    input  PC, ID_Instruction, ID_PCPlus4, ID_Valid, Halted,
    output IF_Instruction, Stall, Flush, Redirect, RedirectTarget, Halt
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC sequencing with stall, flush, redirect and halt,
// plus the IF/ID pipeline register.
//
// state | meaning
// RUN   | fetching; PC advances unless stalled, flushed or halted
// HALT  | fetching stopped, IF/ID holds a bubble; left only through reset
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            Clk,
  input logic            Rst,
  if_fetch_stage_if.master fb
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_t_q, pend_t_d;
  logic [31:0] pc_plus4;
  logic [31:0] tgt_aligned;

  assign pc_plus4    = pc_q + 32'd4;
  assign tgt_aligned = {fb.RedirectTarget[31:2], 2'b00};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == RUN && !fb.Flush && fb.Halt) state_nxt = HALT;
  end

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    pend_v_d = pend_v_q;
    pend_t_d = pend_t_q;
    if (state == RUN) begin
      if (fb.Flush) begin
        instr_d  = '0;
        pc4_d    = '0;
        valid_d  = 1'b0;
        pend_v_d = 1'b0;
        if (fb.Redirect) pc_d = tgt_aligned;
      end else if (fb.Halt) begin
        instr_d  = '0;
        pc4_d    = '0;
        valid_d  = 1'b0;
        pend_v_d = 1'b0;
      end else if (fb.Stall) begin
        // A redirect seen while stalled is remembered; a later one replaces it.
        if (fb.Redirect) begin
          pend_v_d = 1'b1;
          pend_t_d = tgt_aligned;
        end
      end else begin
        instr_d  = fb.IF_Instruction;
        pc4_d    = pc_plus4;
        valid_d  = 1'b1;
        pend_v_d = 1'b0;
        if (fb.Redirect)    pc_d = tgt_aligned;
        else if (pend_v_q)  pc_d = pend_t_q;
        else                pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      pend_v_q <= 1'b0;
      pend_t_q <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      pend_v_q <= pend_v_d;
      pend_t_q <= pend_t_d;
    end
  end

  always_comb begin
    fb.PC             = pc_q;
    fb.ID_Instruction = instr_q;
    fb.ID_PCPlus4     = pc4_q;
    fb.ID_Valid       = valid_q;
    fb.Halted         = (state == HALT);
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: reference model feeds a scoreboard queue,
// plus fixed-value checks of the documented scenarios and a wrap-around instance.
module tb_if_fetch_stage;

  typedef logic [97:0] vec_t;

  logic Clk;
  logic Rst;
  int   total = 0;
  int   bad   = 0;

  vec_t sb[$];

  logic [31:0] m_pc, m_ii, m_ip4, m_pt;
  logic        m_iv, m_halt, m_pv;

  if_fetch_stage_if b();
  if_fetch_stage_if bw();

  if_fetch_stage dut (.Clk(Clk), .Rst(Rst), .fb(b));
  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (.Clk(Clk), .Rst(Rst), .fb(bw));

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign b.IF_Instruction  = mem(b.PC);
  assign bw.IF_Instruction = 32'hCAFE_0000;
  assign bw.Stall          = 1'b0;
  assign bw.Flush          = 1'b0;
  assign bw.Redirect       = 1'b0;
  assign bw.RedirectTarget = 32'h0;
  assign bw.Halt           = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t obs();
    return {b.PC, b.ID_Instruction, b.ID_PCPlus4, b.ID_Valid, b.Halted};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ii = 32'h0; m_ip4 = 32'h0; m_iv = 1'b0;
    m_halt = 1'b0; m_pv = 1'b0; m_pt = 32'h0;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    b.Stall = 1'b0; b.Flush = 1'b0; b.Redirect = 1'b0; b.Halt = 1'b0;
    b.RedirectTarget = 32'h0;
    model_reset();
    #2;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  // Drive one cycle of controls, advance the model, queue its expectation, then clock.
  task automatic step(input logic s, input logic f, input logic r,
                      input logic [31:0] t, input logic h);
    logic [31:0] w;
    logic [31:0] ta;
    b.Stall = s; b.Flush = f; b.Redirect = r; b.RedirectTarget = t; b.Halt = h;
    w  = mem(m_pc);
    ta = t & 32'hFFFF_FFFC;
    if (!m_halt) begin
      if (f) begin
        m_ii = 0; m_ip4 = 0; m_iv = 0; m_pv = 0;
        if (r) m_pc = ta;
      end else if (h) begin
        m_halt = 1; m_ii = 0; m_ip4 = 0; m_iv = 0; m_pv = 0;
      end else if (s) begin
        if (r) begin m_pv = 1; m_pt = ta; end
      end else begin
        m_ii = w; m_ip4 = m_pc + 32'd4; m_iv = 1;
        m_pc = r ? ta : (m_pv ? m_pt : m_pc + 32'd4);
        m_pv = 0;
      end
    end
    sb.push_back({m_pc, m_ii, m_ip4, m_iv, m_halt});
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t exp;
    Rst = 1'b0;
    b.Stall = 0; b.Flush = 0; b.Redirect = 0; b.Halt = 0; b.RedirectTarget = 0;
    model_reset();
    #2;
    exp = {32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    total++;
    if (obs() !== exp) begin
      $display("FAIL reset_state got=%h want=%h", obs(), exp); bad++;
    end
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_sequential();
    vec_t exp;
    do_reset();
    total++;
    if (b.PC !== 32'h0) begin $display("FAIL seq_pc0 got=%h want=0", b.PC); bad++; end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 32'h0, 0);
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) begin $display("FAIL seq_sb%0d got=%h want=%h", i, obs(), exp); bad++; end
    end
    exp = {32'h8, 32'h1000_0001, 32'h8, 1'b1, 1'b0};
    total++;
    if (obs() !== exp) begin $display("FAIL seq_edge2 got=%h want=%h", obs(), exp); bad++; end
  endtask

  task automatic test_stall_redirect();
    vec_t exp;
    // continues from PC=8
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 1, 32'h40, 0);
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) begin $display("FAIL stall_sb%0d got=%h want=%h", i, obs(), exp); bad++; end
      exp = {32'h8, 32'h1000_0001, 32'h8, 1'b1, 1'b0};
      total++;
      if (obs() !== exp) begin $display("FAIL stall_hold%0d got=%h want=%h", i, obs(), exp); bad++; end
    end
    step(0, 0, 0, 32'h0, 0);
    exp = sb.pop_front();
    total++;
    if (obs() !== exp) begin $display("FAIL stall_rel_sb got=%h want=%h", obs(), exp); bad++; end
    exp = {32'h40, 32'h1000_0002, 32'hC, 1'b1, 1'b0};
    total++;
    if (obs() !== exp) begin $display("FAIL stall_release got=%h want=%h", obs(), exp); bad++; end
  endtask

  task automatic test_flush();
    vec_t exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 0);
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) begin $display("FAIL flush_pre%0d got=%h want=%h", i, obs(), exp); bad++; end
    end
    step(1, 0, 1, 32'h80, 0);
    void'(sb.pop_front());
    step(1, 1, 1, 32'h22, 0);
    exp = sb.pop_front();
    total++;
    if (obs() !== exp) begin $display("FAIL flush_sb got=%h want=%h", obs(), exp); bad++; end
    exp = {32'h20, 32'h0, 32'h0, 1'b0, 1'b0};
    total++;
    if (obs() !== exp) begin $display("FAIL flush_redirect got=%h want=%h", obs(), exp); bad++; end
    step(0, 0, 0, 32'h0, 0);
    void'(sb.pop_front());
    exp = {32'h24, 32'h1000_0008, 32'h24, 1'b1, 1'b0};
    total++;
    if (obs() !== exp) begin $display("FAIL flush_pend_clear got=%h want=%h", obs(), exp); bad++; end
    step(0, 1, 0, 32'h0, 0);
    void'(sb.pop_front());
    exp = {32'h24, 32'h0, 32'h0, 1'b0, 1'b0};
    total++;
    if (obs() !== exp) begin $display("FAIL flush_hold got=%h want=%h", obs(), exp); bad++; end
  endtask

  task automatic test_halt();
    vec_t exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'h0, 0);
      void'(sb.pop_front());
    end
    step(0, 0, 0, 32'h0, 1);
    void'(sb.pop_front());
    exp = {32'h10, 32'h0, 32'h0, 1'b0, 1'b1};
    total++;
    if (obs() !== exp) begin $display("FAIL halt_enter got=%h want=%h", obs(), exp); bad++; end
    for (int i = 0; i < 4; i++) begin
      step(i[0], i[1], 1, 32'h300, 0);
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) begin $display("FAIL halt_sb%0d got=%h want=%h", i, obs(), exp); bad++; end
      total++;
      if (b.PC !== 32'h10 || b.ID_Valid !== 1'b0 || b.Halted !== 1'b1) begin
        $display("FAIL halt_hold%0d got_pc=%h got_v=%b got_h=%b want_pc=10 v=0 h=1",
                 i, b.PC, b.ID_Valid, b.Halted);
        bad++;
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t exp;
    // starts from HALT: reset must leave it
    do_reset();
    total++;
    if (b.Halted !== 1'b0) begin $display("FAIL arst_halt_exit got=%b want=0", b.Halted); bad++; end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 32'h0, 0);
      void'(sb.pop_front());
    end
    step(1, 0, 1, 32'h100, 0);
    void'(sb.pop_front());
    #3;
    Rst = 1'b0;
    model_reset();
    #2;
    exp = {32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    total++;
    if (obs() !== exp) begin $display("FAIL arst_immediate got=%h want=%h", obs(), exp); bad++; end
    b.Stall = 0; b.Redirect = 0;
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 0);
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) begin $display("FAIL arst_sb%0d got=%h want=%h", i, obs(), exp); bad++; end
      total++;
      if (b.PC !== 32'(4 * (i + 1))) begin
        $display("FAIL arst_no_pend%0d got=%h want=%h", i, b.PC, 32'(4 * (i + 1))); bad++;
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    total++;
    if (bw.PC !== 32'hFFFF_FFFC) begin $display("FAIL wrap_reset got=%h want=fffffffc", bw.PC); bad++; end
    step(0, 0, 0, 32'h0, 0);
    void'(sb.pop_front());
    total++;
    if (bw.PC !== 32'h0 || bw.ID_PCPlus4 !== 32'h0 || bw.ID_Valid !== 1'b1 ||
        bw.ID_Instruction !== 32'hCAFE_0000) begin
      $display("FAIL wrap_edge1 got_pc=%h got_p4=%h got_v=%b got_i=%h want 0 0 1 cafe0000",
               bw.PC, bw.ID_PCPlus4, bw.ID_Valid, bw.ID_Instruction);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t exp;
    do_reset();
    step(1, 0, 1, 32'h200, 0);
    void'(sb.pop_front());
    step(1, 0, 1, 32'h300, 0);
    void'(sb.pop_front());
    step(0, 0, 0, 32'h0, 0);
    void'(sb.pop_front());
    total++;
    if (b.PC !== 32'h300) begin $display("FAIL b2b_newest got=%h want=300", b.PC); bad++; end
    step(0, 0, 1, 32'h107, 0);
    void'(sb.pop_front());
    exp = {32'h104, 32'h1000_00C0, 32'h304, 1'b1, 1'b0};
    total++;
    if (obs() !== exp) begin $display("FAIL b2b_align got=%h want=%h", obs(), exp); bad++; end
  endtask

  task automatic test_random();
    vec_t exp;
    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 0) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom, $urandom_range(0, 79) == 0);
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) begin $display("FAIL rand_sb%0d got=%h want=%h", i, obs(), exp); bad++; end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_flush();
    test_halt();
    test_async_reset();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
